instr_mem_sync: RTL
===================

Name: instr_mem_sync

Overview:
Synchronous, parametrised successor to the combinational instruction memory. Provides a registered instruction-fetch port and a handshaked data-read port. The data port supports LB/LBU/LH/LHU/LW. Word-crossing loads are split into two internal reads by a small FSM. A byte-strobed write port loads programs, and fault flags report out-of-range and illegal accesses. The block sits between the pipeline IF/MEM stages and the program loader.

Parameters:
DATA_WIDTH, 32, word width (fixed to 32 for RV32).
ADDR_WIDTH, 32, byte-address width.
MEM_SIZE, 1024, depth in 32-bit words.
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
NOP_INSTR, 32'h0000_0013, value returned on fetch fault and used to initialise memory.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
fetch_req  input  1  fetch request, sampled every cycle.
fetch_addr  input  ADDR_WIDTH  fetch byte address.
fetch_valid  output  1  fetch result valid, one cycle after fetch_req.
fetch_instr  output  DATA_WIDTH  fetched instruction.
fetch_fault  output  1  misaligned or out-of-range fetch.
data_req  input  1  load request.
data_addr  input  ADDR_WIDTH  load byte address.
load_type  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
data_ready  output  1  block can accept a load this cycle.
data_valid  output  1  single-cycle pulse; result on data_rdata.
data_rdata  output  DATA_WIDTH  sign- or zero-extended load result.
data_fault  output  1  qualifies data_valid: out-of-range or illegal load_type.
wr_en  input  1  loader write enable.
wr_addr  input  ADDR_WIDTH  write byte address; bits [1:0] ignored.
wr_data  input  DATA_WIDTH  write data.
wr_strb  input  4  byte enables; bit i writes byte lane i.

Behaviour:
- Reset (asynchronous, rst_n low): fetch_valid, fetch_instr, fetch_fault, data_valid, data_rdata and data_fault are 0; the FSM goes to IDLE; data_ready is 1 after release. Memory contents are not reset; they are initialised to NOP_INSTR at elaboration.
- Word index: widx = (addr - BASE_ADDR) >> 2. The index is in range when addr >= BASE_ADDR and widx < MEM_SIZE.
- Fetch port:
  - Latency is 1 cycle, fully independent of the data port.
  - fetch_valid(t+1) = fetch_req(t).
  - If addr[1:0] != 0 or widx is out of range: fetch_instr = NOP_INSTR and fetch_fault = 1.
  - On cycles where fetch_req was 0, fetch_instr holds its previous value and fetch_fault = 0.
- Data port FSM, states IDLE and SPLIT:
  - data_ready = (state == IDLE). A load is accepted when data_req && data_ready.
  - Non-crossing load (LB/LBU any offset; LH/LHU offset 0–2; LW offset 0): read the word; data_valid pulses the next cycle. The FSM stays in IDLE, so back-to-back loads give one result per cycle.
  - Crossing load (LH/LHU offset 3; LW offset 1–3): capture the low word and the low-byte offset, then go to SPLIT with data_ready = 0. In SPLIT, read word widx+1, assemble the result little-endian, and return to IDLE. data_valid pulses 2 cycles after acceptance.
  - Lane selection is little-endian. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
  - Out-of-range word (first or second): that word reads as 0 and data_fault = 1 with data_valid.
  - Illegal load_type (011, 110, 111): data_rdata = 0 and data_fault = 1, with 1-cycle latency.
  - data_rdata holds its value between pulses.
- Write port:
  - Synchronous; each byte lane is written when wr_en && wr_strb[i].
  - Out-of-range writes are silently dropped.
  - Read-during-write to the same word (either port, including the SPLIT second read) returns the old data.
- Reset asserted in SPLIT aborts the load: no data_valid is produced and the FSM returns to IDLE.
- data_req while data_ready = 0 is ignored; the requester must hold the request until it is accepted.

Test Plan:
1. Write word 0 = 32'h8899AABB (strb 1111), then LB at addr 2 -> data_rdata 32'hFFFFFF99 one cycle after accept; LBU at addr 2 -> 32'h00000099.
2. Words 4 = 32'h44332211 and 5 = 32'h88776655; LW at addr 0x11 -> data_ready low for 1 cycle; data_valid 2 cycles after accept with 32'h55443322 and fault 0.
3. LH at addr 0x13 (same data) -> 32'h00005544 after 2 cycles; LHU at addr 0x12 -> 32'h00004433 after 1 cycle.
4. Fetch at BASE_ADDR+MEM_SIZE*4 -> fetch_valid 1, fetch_instr 32'h00000013, fetch_fault 1. Fetch at addr 0x2 -> NOP with fault. LW at last word +1 offset -> upper bytes 0, data_fault 1.
5. Same-cycle wr_en to word 4 (strb 0001, data 32'hFF) and LW at addr 0x10 -> returns 32'h44332211; next LW returns 32'h443322FF.
6. Assert rst_n low during SPLIT -> no data_valid, data_ready 1 after release; load_type 3'b011 -> data_rdata 0 with data_fault 1.

Source files
------------

// File: rtl/instr_mem_sync.sv
// rtl/instr_mem_sync.sv - synchronous instruction memory with fetch, split-capable load and loader write ports
module instr_mem_sync #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [2:0]            load_type,
    output logic                  data_ready,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_fault,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [3:0]            wr_strb
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] MEM_WORDS = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic {IDLE, SPLIT} state_t;

    // Addresses are handled one bit wider so that addr+4 at the top of the space cannot wrap back into range.
    function automatic logic addr_ok(input logic [ADDR_WIDTH:0] a);
        logic [ADDR_WIDTH:0] off;
        off = a - BASE_EXT;
        return (a >= BASE_EXT) && ({2'b00, off[ADDR_WIDTH:2]} < MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH:0] a);
        logic [ADDR_WIDTH:0] off;
        off = a - BASE_EXT;
        return off[IDX_W+1:2];
    endfunction

    // Takes a value already shifted so the addressed byte sits in lane 0, then sizes and extends it.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] lt);
        case (lt[1:0])
            2'b00:   return lt[2] ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   return lt[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE] = '{default: NOP_INSTR};

    state_t state, state_next;

    logic              wr_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic              f_ok;
    logic [IDX_W-1:0]  f_idx;
    logic              d_ok;
    logic [IDX_W-1:0]  d_idx;
    logic [ADDR_WIDTH:0] hi_addr;
    logic              hi_ok;
    logic [IDX_W-1:0]  hi_idx;
    logic [31:0]       d_word;
    logic [31:0]       d_shift;
    logic [1:0]        d_off;
    logic              lt_illegal;
    logic              crossing;
    logic              accept;

    logic [31:0]       lo_word_q;
    logic              lo_fault_q;
    logic [1:0]        off_q;
    logic [2:0]        type_q;
    logic              hi_ok_q;
    logic [IDX_W-1:0]  hi_idx_q;
    logic [31:0]       hi_word;
    logic [63:0]       pair_shift;

    assign wr_ok   = addr_ok({1'b0, wr_addr});
    assign wr_idx  = addr_idx({1'b0, wr_addr});
    assign f_ok    = addr_ok({1'b0, fetch_addr});
    assign f_idx   = addr_idx({1'b0, fetch_addr});
    assign d_ok    = addr_ok({1'b0, data_addr});
    assign d_idx   = addr_idx({1'b0, data_addr});
    assign hi_addr = {1'b0, data_addr} + (ADDR_WIDTH+1)'(4);
    assign hi_ok   = addr_ok(hi_addr);
    assign hi_idx  = addr_idx(hi_addr);

    assign d_off      = data_addr[1:0];
    assign lt_illegal = (load_type == 3'b011) || (load_type == 3'b110) || (load_type == 3'b111);
    assign crossing   = !lt_illegal &&
                        (((load_type[1:0] == 2'b01) && (d_off == 2'd3)) ||
                         ((load_type[1:0] == 2'b10) && (d_off != 2'd0)));
    assign data_ready = (state == IDLE);
    assign accept     = data_req && data_ready;

    // Reads are combinational off the array and registered below, so a same-edge write is seen only afterwards.
    assign d_word     = d_ok ? mem[d_idx] : '0;
    assign d_shift    = d_word >> {d_off, 3'b000};
    assign hi_word    = hi_ok_q ? mem[hi_idx_q] : '0;
    assign pair_shift = {hi_word, lo_word_q} >> {off_q, 3'b000};

    // Loader writes, byte-lane granular; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Fetch port: one-cycle registered read, NOP plus fault on misaligned or out-of-range address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= fetch_req;
            fetch_fault <= 1'b0;
            if (fetch_req) begin
                if ((fetch_addr[1:0] != 2'b00) || !f_ok) begin
                    fetch_instr <= NOP_INSTR;
                    fetch_fault <= 1'b1;
                end else begin
                    fetch_instr <= mem[f_idx];
                end
            end
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Load FSM next state: only word-crossing loads take the extra SPLIT cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && crossing) state_next = SPLIT;
            SPLIT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load datapath: single-word result on accept, or capture the low word and finish in SPLIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            data_rdata <= '0;
            data_fault <= 1'b0;
            lo_word_q  <= '0;
            lo_fault_q <= 1'b0;
            off_q      <= '0;
            type_q     <= '0;
            hi_ok_q    <= 1'b0;
            hi_idx_q   <= '0;
        end else begin
            data_valid <= 1'b0;
            if (state == SPLIT) begin
                data_valid <= 1'b1;
                data_rdata <= extend(pair_shift[31:0], type_q);
                data_fault <= lo_fault_q || !hi_ok_q;
            end else if (accept) begin
                if (lt_illegal) begin
                    data_valid <= 1'b1;
                    data_rdata <= '0;
                    data_fault <= 1'b1;
                end else if (crossing) begin
                    lo_word_q  <= d_word;
                    lo_fault_q <= !d_ok;
                    off_q      <= d_off;
                    type_q     <= load_type;
                    hi_ok_q    <= hi_ok;
                    hi_idx_q   <= hi_idx;
                end else begin
                    data_valid <= 1'b1;
                    data_rdata <= extend(d_shift, load_type);
                    data_fault <= !d_ok;
                end
            end
        end
    end

endmodule
